// File: rtl/fpadd_sched.sv
// fpadd_sched: shares one fixed-latency pipelined FP adder between NREQ
// requesters. Round-robin grant, at most one issue per cycle, a one-hot tag
// pipeline that steers each result and its flags back to its issuer, and a
// drain/idle handshake for quiescing the adder.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   req_valid_i/req_ready_o per-requester handshake (ready is a one-hot grant)
//   req_a_i/req_b_i/req_op_i per-requester operands (packed i*W +: W) and effop
//   add_start_o/add_a_o/add_b_o/add_op_o  registered issue to the adder
//   add_sum_i/add_flags_i/add_done_i      adder result, LAT cycles after start
//   rsp_valid_o/rsp_data_o/rsp_flags_o    one-hot result strobe plus result
//   drain_i/idle_o          stop granting / pipeline empty while draining
//   tag_err_o               sticky: adder done strobe out of step with the tags
//
// Optional build macro FPADD_SCHED_STATS_EN adds stat_clr_i and stat_grants_o
// (one 16-bit saturating grant counter per requester).

`ifdef FPADD_SCHED_STATS_EN
module fpadd_sched_statcnt (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);
  logic [15:0] cnt_q;

  // clear wins over a same-cycle increment; saturate at all-ones
  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i)                 cnt_q <= '0;
    else if (inc_i && cnt_q != 16'hFFFF)  cnt_q <= cnt_q + 16'd1;
  end

  assign cnt_o = cnt_q;
endmodule
`endif

module fpadd_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  parameter int W    = 32,
  parameter int FW   = 5
) (
`ifdef FPADD_SCHED_STATS_EN
  input  logic                 stat_clr_i,
  output logic [NREQ*16-1:0]   stat_grants_o,
`endif
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*W-1:0]    req_a_i,
  input  logic [NREQ*W-1:0]    req_b_i,
  input  logic [NREQ-1:0]      req_op_i,
  output logic                 add_start_o,
  output logic [W-1:0]         add_a_o,
  output logic [W-1:0]         add_b_o,
  output logic                 add_op_o,
  input  logic [W-1:0]         add_sum_i,
  input  logic [FW-1:0]        add_flags_i,
  input  logic                 add_done_i,
  output logic [NREQ-1:0]      rsp_valid_o,
  output logic [W-1:0]         rsp_data_o,
  output logic [FW-1:0]        rsp_flags_o,
  input  logic                 drain_i,
  output logic                 idle_o,
  output logic                 tag_err_o
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(LAT + 2);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_IDLE} state_e;

  state_e                   state_q;
  logic                     idle_q;
  logic [PW-1:0]            ptr_q;
  logic [CW-1:0]            cnt_q, cnt_d;
  // tag pipe: stage 0 lines up with add_start, stage LAT with add_done
  logic [LAT:0]             vld_pipe_q;
  logic [LAT:0][NREQ-1:0]   tag_pipe_q;

  logic                     add_start_q, add_op_q, tag_err_q;
  logic [W-1:0]             add_a_q, add_b_q, rsp_data_q;
  logic [NREQ-1:0]          rsp_valid_q;
  logic [FW-1:0]            rsp_flags_q;

  logic [NREQ-1:0]          gnt;
  logic [PW-1:0]            gnt_idx;
  logic                     gnt_any;
  logic                     done_ok;
  int                       idx;

  // Round-robin search upward from ptr. drain_i gates directly so a request
  // in the cycle drain rises is never granted.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    if (state_q == S_RUN && !drain_i) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr_q) + k) % NREQ;
        if (!gnt_any && req_valid_i[idx]) begin
          gnt_any      = 1'b1;
          gnt[idx]     = 1'b1;
          gnt_idx      = PW'(idx);
        end
      end
    end
  end

  assign req_ready_o = gnt;
  assign done_ok     = add_done_i & vld_pipe_q[LAT];

  always_comb begin
    cnt_d = cnt_q;
    if (gnt_any && !done_ok)      cnt_d = cnt_q + CW'(1);
    else if (!gnt_any && done_ok) cnt_d = cnt_q - CW'(1);
  end

  // issue, tag pipe, return path
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q       <= '0;
      cnt_q       <= '0;
      vld_pipe_q  <= '0;
      tag_pipe_q  <= '0;
      add_start_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_op_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      tag_err_q   <= 1'b0;
    end else begin
      add_start_q <= gnt_any;
      if (gnt_any) begin
        add_a_q  <= req_a_i[gnt_idx*W +: W];
        add_b_q  <= req_b_i[gnt_idx*W +: W];
        add_op_q <= req_op_i[gnt_idx];
        ptr_q    <= (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);
      end
      // the entry at depth LAT falls off the end whether consumed or dropped
      vld_pipe_q  <= {vld_pipe_q[LAT-1:0], gnt_any};
      tag_pipe_q  <= {tag_pipe_q[LAT-1:0], gnt};
      cnt_q       <= cnt_d;
      rsp_valid_q <= done_ok ? tag_pipe_q[LAT] : '0;
      if (done_ok) begin
        rsp_data_q  <= add_sum_i;
        rsp_flags_q <= add_flags_i;
      end
      // done without a tag, or a tag without done
      if (add_done_i != vld_pipe_q[LAT]) tag_err_q <= 1'b1;
    end
  end

  // drain/quiesce state machine with registered idle
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_RUN;
      idle_q  <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (drain_i) state_q <= S_DRAIN;
          idle_q <= 1'b0;
        end
        S_DRAIN: begin
          if (!drain_i) begin
            state_q <= S_RUN;
            idle_q  <= 1'b0;
          end else if (cnt_q == '0 && vld_pipe_q == '0) begin
            state_q <= S_IDLE;
            idle_q  <= 1'b1;
          end else begin
            idle_q  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (!drain_i) begin
            state_q <= S_RUN;
            idle_q  <= 1'b0;
          end else begin
            idle_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_RUN;
          idle_q  <= 1'b0;
        end
      endcase
    end
  end

  assign add_start_o = add_start_q;
  assign add_a_o     = add_a_q;
  assign add_b_o     = add_b_q;
  assign add_op_o    = add_op_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_flags_o = rsp_flags_q;
  assign idle_o      = idle_q;
  assign tag_err_o   = tag_err_q;

`ifdef FPADD_SCHED_STATS_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    fpadd_sched_statcnt u_cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clr_i   (stat_clr_i),
      .inc_i   (gnt[i]),
      .cnt_o   (stat_grants_o[i*16 +: 16])
    );
  end
`endif

endmodule

// File: doc/fpadd_sched.md
Name: fpadd_sched

Overview:
- Shares one fixed-latency pipelined FP adder (normalize/round datapath) between NREQ requesters.
- Arbitration is round-robin. The block issues at most one operation per cycle into the adder.
- It tracks each in-flight operation with a tag pipeline and steers each result plus its exception flags back to the requester that issued it.
- A drain/quiesce control lets the system stop issue and wait for the adder pipeline to empty, e.g. before reconfiguring rounding or trap modes.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 3, adder latency in cycles from add_start to add_done (1..8).
- W, 32, operand/result width.
- FW, 5, exception flag width (inex, under, over, zero, denorm).

Ports:
- clk  in  1  clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  one-hot grant; handshake completes when req_valid[i] & req_ready[i].
- req_a  in  NREQ*W  operand A, requester i occupies bits [i*W +: W].
- req_b  in  NREQ*W  operand B, same packing.
- req_op  in  NREQ  effective operation per requester, 0=add, 1=sub.
- add_start  out  1  issue strobe to adder.
- add_a  out  W  registered operand A.
- add_b  out  W  registered operand B.
- add_op  out  1  registered effop.
- add_sum  in  W  adder result, valid with add_done.
- add_flags  in  FW  adder exception flags, valid with add_done.
- add_done  in  1  adder result strobe, expected exactly LAT cycles after add_start.
- rsp_valid  out  NREQ  one-hot result strobe, 1 cycle, no backpressure.
- rsp_data  out  W  registered result.
- rsp_flags  out  FW  registered flags.
- drain  in  1  level; while high, no new grants are made.
- idle  out  1  high when drain is high and nothing is in flight.
- tag_err  out  1  sticky error flag.

Behaviour:
- Reset values:
  - req_ready=0, add_start=0, add_a/add_b=0, add_op=0.
  - rsp_valid=0, rsp_data=0, rsp_flags=0.
  - idle=0, tag_err=0.
  - RR pointer=0, in-flight count=0, tag pipe cleared, state=RUN.
- Arbitration:
  - req_ready is combinational from req_valid, the RR pointer and the state.
  - Grant goes to the first i with req_valid[i]=1, searching upward from ptr and wrapping modulo NREQ.
  - On a grant, ptr <= granted index + 1 (mod NREQ).
  - req_ready is all-zero whenever state != RUN.
- Issue:
  - On a grant, add_start=1 the next cycle, with the selected operands registered.
  - A 1-hot tag (NREQ bits) plus a valid bit enter a LAT+1 deep shift register.
  - Throughput is one op per cycle.
- Return:
  - When add_done=1, the tag at pipe depth LAT is consumed.
  - rsp_valid <= that tag; rsp_data/rsp_flags are registered from add_sum/add_flags.
  - Result latency: grant cycle + 1 + LAT + 1 cycles.
- tag_err is set (sticky until reset) on either condition:
  - add_done=1 with no valid tag at depth LAT; rsp_valid stays 0 in this case.
  - A valid tag at depth LAT with add_done=0; that tag is dropped.
- In-flight counter:
  - Width clog2(LAT+2).
  - Increments on grant, decrements on add_done with a valid tag.
  - Simultaneous increment and decrement leaves it unchanged.
- State machine:
  - RUN -> DRAIN when drain=1.
  - DRAIN -> IDLE when count=0 and no tag is valid.
  - IDLE -> RUN when drain=0.
  - DRAIN -> RUN when drain=0 before the pipe empties.
  - idle=1 only in IDLE.
  - A request presented in the same cycle drain rises is not granted.
- Simultaneous events:
  - A grant and a return in the same cycle are both processed.
  - A requester may be granted in the same cycle its previous result returns.
- Reset mid-operation: all in-flight tags are discarded and no rsp_valid is produced for them. The adder is not reset by this block.
- No-request cycles: ptr holds and add_start=0.

Optional Feature:
- FPADD_SCHED_STATS_EN.
- When defined, the block adds output stat_grants, width NREQ*16: one 16-bit saturating grant counter per requester. Each counter:
  - increments on its requester's grant;
  - holds at 0xFFFF;
  - clears on reset.
- It also adds input stat_clr, which zeroes all counters synchronously; stat_clr takes priority over a same-cycle increment.
- When undefined, neither port exists, no counter logic is present, and all other behaviour is identical.

Test Plan:
- Single requester, NREQ=4, LAT=3: req_valid=0001, a=0x3F800000, b=0x40000000, op=0.
  - add_start one cycle after the grant.
  - Model adder returns 0x40400000 three cycles later.
  - rsp_valid=0001 and rsp_data=0x40400000 one cycle after that.
- All four requesters held valid for 8 cycles: grants are 0001, 0010, 0100, 1000, 0001, ...
  - Eight back-to-back add_start pulses.
  - Results return in issue order with matching one-hot tags.
- Requesters 1 and 3 only, ptr=2: grant 3 first, then 1, then 3.
- Drain: assert drain with 3 ops in flight.
  - req_ready drops immediately.
  - idle rises one cycle after the third rsp_valid.
  - Deassert drain: a grant occurs next cycle.
- Fault: inject an add_done with no issue → tag_err=1, no rsp_valid. Assert reset → tag_err=0.
- With FPADD_SCHED_STATS_EN: 70000 grants to requester 0 → stat_grants[15:0]=0xFFFF. Pulse stat_clr → 0.
